// File: rtl/masked_random_source_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | masked_random_source_if: mask-vector valid/ready channel (r, p)      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface masked_random_source_if #(
  parameter int NUM_SHARES = 3,
  parameter int BIT_WIDTH  = 1
);
  localparam int NUM_QUADRATIC = NUM_SHARES * (NUM_SHARES - 1) / 2;

  logic [NUM_QUADRATIC-1:0][BIT_WIDTH-1:0] out_r;
  logic [NUM_QUADRATIC-1:0][BIT_WIDTH-1:0] out_p;
  logic                                    out_valid;
  logic                                    in_ready;

  modport master (output out_r, output out_p, output out_valid, input in_ready);
  modport slave  (input out_r, input out_p, input out_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/masked_random_source.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | masked_random_source: xorshift128 expander producing HPC3 masks      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module masked_random_source #(
  parameter int NUM_SHARES = 3,
  parameter int BIT_WIDTH  = 1
) (
  input  wire logic              in_clock,
  input  wire logic              in_reset,
  input  wire logic              in_seed_valid,
  input  wire logic [127:0]      in_seed,
  output logic                   out_error,
  masked_random_source_if.master rnd
);
  localparam int NUM_QUADRATIC = NUM_SHARES * (NUM_SHARES - 1) / 2;
  localparam int LANE_W        = NUM_QUADRATIC * BIT_WIDTH;
  localparam int OUT_W         = 2 * LANE_W;
  localparam int STEPS         = (OUT_W + 31) / 32;
  localparam int ACC_W         = 32 * STEPS;
  localparam int CNT_W         = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [31:0]        x, y, z, w;
  logic [31:0]        x_n, y_n, z_n, w_n;
  logic [ACC_W-1:0]   acc, acc_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [LANE_W-1:0]  r_n, p_n;
  logic               valid_n, error_n;
  logic [31:0]        t, w_step;
  logic [ACC_W-1:0]   acc_step;

  // One xorshift128 step and the accumulator with its word slotted in.
  always_comb begin
    t        = x ^ (x << 11);
    w_step   = w ^ (w >> 19) ^ t ^ (t >> 8);
    acc_step = acc;
    acc_step[{cnt, 5'd0} +: 32] = w_step;
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    z_n     = z;
    w_n     = w;
    acc_n   = acc;
    cnt_n   = cnt;
    r_n     = rnd.out_r;
    p_n     = rnd.out_p;
    valid_n = rnd.out_valid;
    error_n = out_error;

    // A seed overrides everything; an all-zero seed would lock the generator.
    if (in_seed_valid) begin
      valid_n = 1'b0;
      if (in_seed != '0) begin
        {x_n, y_n, z_n, w_n} = in_seed;
        cnt_n   = '0;
        acc_n   = '0;
        error_n = 1'b0;
        state_n = FILL;
      end else begin
        error_n = 1'b1;
        state_n = IDLE;
      end
    end else begin
      case (state)
        FILL: begin
          x_n   = y;
          y_n   = z;
          z_n   = w;
          w_n   = w_step;
          acc_n = acc_step;
          if (cnt == LAST_WORD) begin
            r_n     = acc_step[LANE_W-1:0];
            p_n     = acc_step[OUT_W-1:LANE_W];
            valid_n = 1'b1;
            cnt_n   = '0;
            state_n = VALID;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        VALID: begin
          if (rnd.in_ready) begin
            valid_n = 1'b0;
            cnt_n   = '0;
            state_n = FILL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      z             <= '0;
      w             <= '0;
      acc           <= '0;
      cnt           <= '0;
      rnd.out_r     <= '0;
      rnd.out_p     <= '0;
      rnd.out_valid <= 1'b0;
      out_error     <= 1'b0;
    end else begin
      state         <= state_n;
      x             <= x_n;
      y             <= y_n;
      z             <= z_n;
      w             <= w_n;
      acc           <= acc_n;
      cnt           <= cnt_n;
      rnd.out_r     <= r_n;
      rnd.out_p     <= p_n;
      rnd.out_valid <= valid_n;
      out_error     <= error_n;
    end
  end
endmodule
`default_nettype wire

// File: doc/masked_random_source.md
Name: masked_random_source

Overview:
Producer end of the randomness interface of the HPC3 masked multipliers. It expands a 128-bit seed with an xorshift128 generator into fresh mask vectors (r, p). Each vector has NUM_QUADRATIC lanes of BIT_WIDTH bits, as the multiplier's in_r/in_p ports expect. Vectors are delivered over a valid/ready handshake, and one instance feeds one multiplier or a group of multipliers through the AES datapath controller.

Parameters:
NUM_SHARES, 3, number of shares of the consuming multiplier; NUM_QUADRATIC = num_quad(NUM_SHARES) from aes128_package.
BIT_WIDTH, 1, bits per lane.
Derived OUT_W = 2*NUM_QUADRATIC*BIT_WIDTH; STEPS = ceil(OUT_W/32).

Ports:
in_clock  input  1  clock, rising edge.
in_reset  input  1  reset, asynchronous, active-high.
in_seed_valid  input  1  load in_seed this cycle.
in_seed  input  128  seed; {x,y,z,w}, x = bits[127:96], w = bits[31:0].
out_r  output  NUM_QUADRATIC x BIT_WIDTH  packed array T[NUM_QUADRATIC-1:0], maps to multiplier in_r.
out_p  output  NUM_QUADRATIC x BIT_WIDTH  packed array, maps to multiplier in_p.
out_valid  output  1  out_r/out_p hold a fresh, unconsumed vector.
in_ready  input  1  consumer takes the vector when out_valid && in_ready.
out_error  output  1  sticky: last seed was all-zero; generator halted.

Behaviour:
- One clock domain. Reset is asynchronous and active-high, on in_clock / in_reset.
- Reset values: state IDLE; x,y,z,w = 0; accumulator = 0; word counter = 0; out_r = 0, out_p = 0, out_valid = 0, out_error = 0.
- Generator step (xorshift128):
  - t = x ^ (x<<11)
  - x<=y; y<=z; z<=w
  - w <= w ^ (w>>19) ^ t ^ (t>>8)
  - The emitted word is the new w. All arithmetic is 32-bit and truncating.
- Packing:
  - Word k (k = 0..STEPS-1) of a vector fills accumulator bits [32k+31:32k].
  - out_r = acc[NUM_QUADRATIC*BIT_WIDTH-1:0].
  - out_p = acc[OUT_W-1:NUM_QUADRATIC*BIT_WIDTH].
  - Accumulator bits at OUT_W and above are discarded.
- FSM states:
  - IDLE: no valid seed. Generator frozen, out_valid = 0. Leaves only via in_seed_valid.
  - FILL: one step per cycle and word counter increments. After the step that writes word STEPS-1, the registered outputs update and the next state is VALID. out_valid rises on the cycle after the last step. Fill latency = STEPS cycles.
  - VALID: out_valid = 1 and generator frozen. out_r/out_p stay stable until accepted, even when in_ready = 0 for any number of cycles. On out_valid && in_ready: next state FILL, counter = 0, out_valid = 0 next cycle. Throughput is one vector per STEPS+1 cycles.
- Seeding:
  - in_seed_valid is honoured in any state and has priority over acceptance and over a fill step in the same cycle.
  - A nonzero seed loads x,y,z,w, clears counter and accumulator, clears out_error, and sets the next state to FILL. out_valid drops next cycle, so an unaccepted vector is discarded.
  - First output after a seed: out_valid rises STEPS+1 cycles after the seed cycle.
  - An all-zero seed does not load. It sets out_error, state = IDLE and out_valid = 0 next cycle.
  - out_error clears only on a nonzero seed or on reset.
- Simultaneous accept and seed: the seed wins. The handshake in that cycle counts as a transfer of the current vector, so the consumer may latch it.
- Reset asserted mid-fill or in VALID returns immediately (asynchronously) to the reset values. After release the block is in IDLE and needs a reseed.
- State never reaches all-zero from a nonzero seed; no lock-up handling is required.

Test Plan:
1. NUM_SHARES=3, BIT_WIDTH=1 (OUT_W=6, STEPS=1); seed {123456789, 362436069, 521288629, 88675123} -> out_valid high 2 cycles later; first word 0xDCA345EA gives out_r = 3'b010, out_p = 3'b101.
2. Same seed with in_ready held 0 for 10 cycles -> out_r/out_p and out_valid constant. in_ready pulsed once -> out_valid low for exactly 1 cycle, then the second xorshift word appears.
3. NUM_SHARES=5, BIT_WIDTH=8 (NUM_QUADRATIC=10, OUT_W=160, STEPS=5); seed as in 1, in_ready tied 1 -> out_valid pulses every 6 cycles. Each vector equals five consecutive model words packed word 0 at LSB.
4. All-zero seed while in VALID -> next cycle out_valid=0 and out_error=1, and they stay so for 20 cycles. Then nonzero seed -> out_error=0 next cycle, and first vector after STEPS+1 cycles.
5. in_seed_valid and out_valid&&in_ready in the same cycle -> generator restarts from the new seed. No vector from the old stream appears afterwards.
6. in_reset asserted asynchronously mid-fill (STEPS=5, after word 2) -> all outputs 0 immediately. After release, out_valid stays 0 until a new seed.
